sipo_deser: RTL

SIPO_DESER -- requirements
Module: sipo_deser

---
 rtl/sipo_deser.sv | 79 +++++++
 1 files changed

// File: rtl/sipo_deser.sv
// +----------------------------------------------------------------------------+
// | sipo_deser: serial-in / parallel-out deserializer with a holding register, |
// | ready/valid output handshake and a sticky overrun flag.  Rev 1.0           |
// +----------------------------------------------------------------------------+
`default_nettype none

module sipo_deser #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic [4:0]       bit_cnt,
  output logic             overrun,
  input  logic             ovr_clr
);

  localparam logic [4:0] LAST_BIT = 5'(WIDTH - 1);

  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic             word_done;
  logic             hold_free;
  logic             handshake;

  // Bit order only changes the shift direction; everything downstream is shared.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shift_next = {shift_reg[WIDTH-2:0], sin};
    end else begin : g_lsb_first
      assign shift_next = {sin, shift_reg[WIDTH-1:1]};
    end
  endgenerate

  assign word_done = sin_valid && (bit_cnt == LAST_BIT);
  assign handshake = pout_valid && pout_ready;
  assign hold_free = !pout_valid || pout_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (sin_valid) begin
      shift_reg <= shift_next;
      bit_cnt   <= word_done ? 5'd0 : bit_cnt + 5'd1;
    end
  end

  // The completing bit is taken from shift_next so the word is visible right after its last edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pout       <= '0;
      pout_valid <= 1'b0;
    end else if (word_done && hold_free) begin
      pout       <= shift_next;
      pout_valid <= 1'b1;
    end else if (handshake) begin
      pout_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (word_done && !hold_free) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

`default_nettype wire
